// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, derived active-area offsets and lock FSM encoding
// for the VGA sync decoder.
package vga_timing_pkg;

  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_LOCK_FRAMES = 2;

  localparam int H_START = DEF_H_SYNC + DEF_H_BP;
  localparam int V_START = DEF_V_SYNC + DEF_V_BP;

  // Recovered counters are 10 bits wide and stick at all-ones when sync vanishes.
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;

  function automatic logic [9:0] sat_inc(input logic [9:0] value);
    return (value == CNT_MAX) ? value : value + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Samples an active-low sync line on each pixel strobe and flags the
// high-to-low transition against the previously registered sample.
module vga_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic sync_i,
  output logic fall_o
);

  logic sync_q;

  // Idle level of an active-low sync is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 1'b1;
    end else if (en_i) begin
      sync_q <= sync_i;
    end
  end

  assign fall_o = en_i & sync_q & ~sync_i;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers VGA raster position from hSync/vSync, qualifies timing lock and
// reports length errors. Optional pixel probe enabled by defining VGA_PROBE_EN.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_cnt,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [11:0] probe_rgb,
  output logic        probe_valid
);

  localparam logic [9:0]  H_LINE_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_FRAME_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_LO         = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  V_LO         = 10'(V_SYNC + V_BP);
  localparam logic [10:0] H_HI         = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_HI         = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0]  LOCK_N       = 8'(LOCK_FRAMES);

  logic        h_fall;
  logic        v_fall;
  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  lock_state_e state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        frame_bad_q, frame_bad_d;
  logic        h_err_q, h_err_d;
  logic        v_err_q, v_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        fcnt_inc;
  logic        sync_lost;
  logic        line_ok;
  logic        frame_ok;
  logic        line_bad;
  logic        frame_good;
  logic        h_in;
  logic        v_in;

  vga_edge_det u_hsync_det (
    .clk_i  (clock),
    .rst_ni (clear),
    .en_i   (pix_en),
    .sync_i (hSync),
    .fall_o (h_fall)
  );

  vga_edge_det u_vsync_det (
    .clk_i  (clock),
    .rst_ni (clear),
    .en_i   (pix_en),
    .sync_i (vSync),
    .fall_o (v_fall)
  );

  // Raster counters: lines are counted on hSync falls, frames restart on vSync falls.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (h_fall) begin
      hcount_d = '0;
      vcount_d = v_fall ? '0 : sat_inc(vcount_q);
    end else if (pix_en) begin
      hcount_d = sat_inc(hcount_q);
    end
  end

  // At a fall the counters still hold the last index of the finished line/frame.
  assign line_ok    = (hcount_q == H_LINE_LAST);
  assign frame_ok   = (vcount_q == V_FRAME_LAST);
  assign line_bad   = h_fall & ~line_ok;
  assign frame_good = ~frame_bad_q & ~line_bad & frame_ok;
  assign sync_lost  = pix_en & (hcount_d == CNT_MAX);

  assign frame_bad_d = v_fall ? 1'b0 : (frame_bad_q | line_bad);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      frame_bad_q <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (sync_lost) begin
      state_d = ST_SEARCH;
      good_d  = '0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (v_fall) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end
        ST_ACQUIRE: begin
          if (v_fall) begin
            if (!frame_good) begin
              good_d = '0;
            end else if (good_q + 8'd1 >= LOCK_N) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + 8'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (line_bad || (v_fall && !frame_ok)) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          good_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked   = (state_q == ST_LOCKED);
    h_err_d  = 1'b0;
    v_err_d  = 1'b0;
    fcnt_inc = 1'b0;
    if (state_q == ST_LOCKED && !sync_lost) begin
      h_err_d  = line_bad;
      v_err_d  = v_fall & ~frame_ok;
      fcnt_inc = v_fall;
    end
  end

  assign frame_cnt_d = fcnt_inc ? frame_cnt_q + 16'd1 : frame_cnt_q;

  // Error flags are re-evaluated every clock so they last exactly one cycle.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      h_err_q     <= h_err_d;
      v_err_q     <= v_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign h_in   = (hcount_q >= H_LO) && ({1'b0, hcount_q} < H_HI);
  assign v_in   = (vcount_q >= V_LO) && ({1'b0, vcount_q} < V_HI);
  assign bright = h_in & v_in;
  assign pix_x  = bright ? hcount_q - H_LO : '0;
  assign pix_y  = bright ? vcount_q - V_LO : '0;

  assign hCount    = hcount_q;
  assign vCount    = vcount_q;
  assign h_err     = h_err_q;
  assign v_err     = v_err_q;
  assign frame_cnt = frame_cnt_q;

`ifdef VGA_PROBE_EN
  logic        probe_hit;
  logic [11:0] probe_rgb_q;
  logic        probe_valid_q;

  assign probe_hit = locked & bright & (pix_x == probe_x) & (pix_y == probe_y);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
    end else begin
      probe_valid_q <= pix_en & probe_hit;
      if (pix_en && probe_hit) begin
        probe_rgb_q <= {red, green, blue};
      end
    end
  end

  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
`else
  logic unused_probe_inputs;
  assign unused_probe_inputs = ^{red, green, blue, probe_x, probe_y};
  assign probe_rgb   = '0;
  assign probe_valid = 1'b0;
`endif

endmodule
